// File: rtl/execute_unit.sv
// Execute stage: single-cycle ALU/branch/address ops, fixed-latency
// multiply and a restoring divider behind a valid/ready handshake.
module execute_unit #(
  parameter int XLEN       = 32,
  parameter int ENABLE_M   = 1,
  parameter int MUL_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_addr,
  input  logic            in_noop,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic [6:0]      in_funct7,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_noop,
  output logic [XLEN-1:0] out_res,
  output logic            busy
);

  localparam int SH = $clog2(XLEN);
  localparam int HW = 12 - SH;
  localparam int CW = $clog2(XLEN + 1);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPI   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [HW-1:0]   SRA_HI = {2'b01, {(HW-2){1'b0}}};
  localparam logic [XLEN-1:0] MIN_V  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      f3_q, f3_d;
  logic            neg_q, neg_d;
  logic            isrem_q, isrem_d;
  logic            ov_q, ov_d;
  logic            on_q, on_d;
  logic [XLEN-1:0] res_q, res_d;

  logic            accept;
  logic [XLEN-1:0] rs1, rs2;
  logic [HW-1:0]   imm_hi;

  assign rs1    = in_rs1_data;
  assign rs2    = in_rs2_data;
  assign imm_hi = in_imm[11:SH];
  assign accept = in_valid && in_ready;

  function automatic logic [XLEN-1:0] alu(
    input logic [2:0]      f,
    input logic            alt,
    input logic [XLEN-1:0] x,
    input logic [XLEN-1:0] y
  );
    logic [SH-1:0] s;
    s = y[SH-1:0];
    unique case (f)
      3'b000: return alt ? x - y : x + y;
      3'b001: return x << s;
      3'b010: return XLEN'($signed(x) < $signed(y));
      3'b011: return XLEN'(x < y);
      3'b100: return x ^ y;
      3'b101: return alt ? XLEN'($signed(x) >>> s) : x >> s;
      3'b110: return x | y;
      3'b111: return x & y;
    endcase
  endfunction

  // Single-cycle decode; M-ops only flag their class here.
  logic [XLEN-1:0] dec_res;
  logic            dec_noop, dec_mul, dec_div;

  always_comb begin
    dec_res  = '0;
    dec_noop = 1'b1;
    dec_mul  = 1'b0;
    dec_div  = 1'b0;
    unique case (1'b1)
      in_opcode == OPC_OP: begin
        if (in_funct7 == 7'b0000000) begin
          dec_res  = alu(in_funct3, 1'b0, rs1, rs2);
          dec_noop = 1'b0;
        end else if (in_funct7 == 7'b0100000 &&
                     (in_funct3 == 3'b000 || in_funct3 == 3'b101)) begin
          dec_res  = alu(in_funct3, 1'b1, rs1, rs2);
          dec_noop = 1'b0;
        end else if (in_funct7 == 7'b0000001 && ENABLE_M != 0) begin
          dec_mul  = !in_funct3[2];
          dec_div  = in_funct3[2];
          dec_noop = 1'b0;
        end
      end
      in_opcode == OPC_OPI: begin
        if (in_funct3 == 3'b001) begin
          if (imm_hi == '0) begin
            dec_res  = alu(3'b001, 1'b0, rs1, in_imm);
            dec_noop = 1'b0;
          end
        end else if (in_funct3 == 3'b101) begin
          if (imm_hi == '0 || imm_hi == SRA_HI) begin
            dec_res  = alu(3'b101, imm_hi[HW-2], rs1, in_imm);
            dec_noop = 1'b0;
          end
        end else begin
          dec_res  = alu(in_funct3, 1'b0, rs1, in_imm);
          dec_noop = 1'b0;
        end
      end
      in_opcode == OPC_LOAD || in_opcode == OPC_STORE: begin
        dec_res  = rs1 + in_imm;
        dec_noop = 1'b0;
      end
      in_opcode == OPC_BR: begin
        dec_noop = 1'b0;
        unique case (in_funct3)
          3'b000: dec_res = XLEN'(rs1 == rs2);
          3'b001: dec_res = XLEN'(rs1 != rs2);
          3'b100: dec_res = XLEN'($signed(rs1) < $signed(rs2));
          3'b101: dec_res = XLEN'($signed(rs1) >= $signed(rs2));
          3'b110: dec_res = XLEN'(rs1 < rs2);
          3'b111: dec_res = XLEN'(rs1 >= rs2);
          default: dec_noop = 1'b1;
        endcase
      end
      in_opcode == OPC_JAL: begin
        dec_res  = in_addr + XLEN'(4);
        dec_noop = 1'b0;
      end
      in_opcode == OPC_JALR: begin
        if (in_funct3 == 3'b000) begin
          dec_res  = in_addr + XLEN'(4);
          dec_noop = 1'b0;
        end
      end
      in_opcode == OPC_LUI: begin
        dec_res  = in_imm;
        dec_noop = 1'b0;
      end
      in_opcode == OPC_AUIPC: begin
        dec_res  = in_addr + in_imm;
        dec_noop = 1'b0;
      end
      default: ;
    endcase
    if (in_noop) begin
      dec_res  = '0;
      dec_noop = 1'b1;
      dec_mul  = 1'b0;
      dec_div  = 1'b0;
    end
  end

  // Divide-by-zero and signed overflow bypass the iterative path.
  logic            dsgn, drem, dzero, dovf;
  logic [XLEN-1:0] dspec_res;

  always_comb begin
    dsgn      = !in_funct3[0];
    drem      = in_funct3[1];
    dzero     = (rs2 == '0);
    dovf      = dsgn && (rs1 == MIN_V) && (&rs2);
    dspec_res = dzero ? (drem ? rs1 : '1) : (drem ? '0 : rs1);
  end

  // Operands come straight from the inputs when MUL_STAGES is 1.
  logic [XLEN-1:0]   mul_a, mul_b, mul_res;
  logic [2:0]        mul_f3;
  logic              mul_sa, mul_sb;
  logic [2*XLEN-1:0] mul_ea, mul_eb, mul_p;

  always_comb begin
    mul_a   = (state_q == S_MUL) ? a_q : rs1;
    mul_b   = (state_q == S_MUL) ? b_q : rs2;
    mul_f3  = (state_q == S_MUL) ? f3_q : in_funct3;
    mul_sa  = (mul_f3 == 3'b001) || (mul_f3 == 3'b010);
    mul_sb  = (mul_f3 == 3'b001);
    mul_ea  = {{XLEN{mul_sa & mul_a[XLEN-1]}}, mul_a};
    mul_eb  = {{XLEN{mul_sb & mul_b[XLEN-1]}}, mul_b};
    mul_p   = mul_ea * mul_eb;
    mul_res = (mul_f3 == 3'b000) ? mul_p[XLEN-1:0]
                                 : mul_p[2*XLEN-1:XLEN];
  end

  logic [XLEN:0]   rem_sh, diff;
  logic [XLEN-1:0] step_quo, step_rem, div_mag;

  always_comb begin
    rem_sh = {rem_q, a_q[XLEN-1]};
    diff   = rem_sh - {1'b0, b_q};
    if (!diff[XLEN]) begin
      step_rem = diff[XLEN-1:0];
      step_quo = {a_q[XLEN-2:0], 1'b1};
    end else begin
      step_rem = rem_sh[XLEN-1:0];
      step_quo = {a_q[XLEN-2:0], 1'b0};
    end
    div_mag = isrem_q ? step_rem : step_quo;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    neg_d   = neg_q;
    isrem_d = isrem_q;
    ov_d    = ov_q && !out_ready;
    on_d    = on_q;
    res_d   = res_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (dec_mul && MUL_STAGES > 1) begin
            state_d = S_MUL;
            a_d     = rs1;
            b_d     = rs2;
            f3_d    = in_funct3;
            cnt_d   = CW'(MUL_STAGES - 1);
          end else if (dec_mul) begin
            ov_d  = 1'b1;
            on_d  = 1'b0;
            res_d = mul_res;
          end else if (dec_div && !(dzero || dovf)) begin
            state_d = S_DIV;
            a_d     = (dsgn && rs1[XLEN-1]) ? -rs1 : rs1;
            b_d     = (dsgn && rs2[XLEN-1]) ? -rs2 : rs2;
            rem_d   = '0;
            cnt_d   = CW'(XLEN);
            isrem_d = drem;
            neg_d   = dsgn && (drem ? rs1[XLEN-1]
                                    : rs1[XLEN-1] ^ rs2[XLEN-1]);
          end else if (dec_div) begin
            ov_d  = 1'b1;
            on_d  = 1'b0;
            res_d = dspec_res;
          end else begin
            ov_d  = 1'b1;
            on_d  = dec_noop;
            res_d = dec_res;
          end
        end
      end
      S_MUL: begin
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          ov_d    = 1'b1;
          on_d    = 1'b0;
          res_d   = mul_res;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DIV: begin
        a_d   = step_quo;
        rem_d = step_rem;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          ov_d    = 1'b1;
          on_d    = 1'b0;
          res_d   = neg_q ? -div_mag : div_mag;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      f3_q    <= '0;
      neg_q   <= 1'b0;
      isrem_q <= 1'b0;
      ov_q    <= 1'b0;
      on_q    <= 1'b1;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      neg_q   <= neg_d;
      isrem_q <= isrem_d;
      ov_q    <= ov_d;
      on_q    <= on_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = rst_n && (state_q == S_IDLE) && (!ov_q || out_ready);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = ov_q;
  assign out_noop  = on_q;
  assign out_res   = res_q;

endmodule
